// File: rtl/pll_reconfig_seq_if.sv
// Avalon-MM style management bus between the reconfiguration sequencer and the PLL
// reconfig controller.
interface pll_reconfig_seq_if;
    logic        mgmt_write;
    logic [5:0]  mgmt_address;
    logic [31:0] mgmt_writedata;
    logic        mgmt_waitrequest;

    modport master (
        output mgmt_write,
        output mgmt_address,
        output mgmt_writedata,
        input  mgmt_waitrequest
    );

    modport slave (
        input  mgmt_write,
        input  mgmt_address,
        input  mgmt_writedata,
        output mgmt_waitrequest
    );
endinterface

// File: rtl/pll_reconfig_seq.sv
// PLL reconfiguration sequencer: issues the eight-register write sequence, pulses the PLL
// reset, then waits for lock with a saturating timeout.
module pll_reconfig_seq #(
    parameter int unsigned GAP          = 8,
    parameter int unsigned RST_CYCLES   = 8,
    parameter int unsigned LOCK_TIMEOUT = 50000000
) (
    input  logic               CLK_50M,
    input  logic               RESET,
    input  logic               start,
    input  logic [31:0]        m_val,
    input  logic [31:0]        k_val,
    input  logic [31:0]        c0_val,
    input  logic               locked,
    pll_reconfig_seq_if.master mgmt,
    output logic               pll_reset,
    output logic               busy,
    output logic               done,
    output logic               error
);
    typedef enum logic [2:0] {StIdle, StWrite, StGap, StPllRst, StWaitLock} state_e;

    state_e      r_state, w_state_next;
    logic [2:0]  r_idx, w_idx_next;
    logic [31:0] r_cnt, w_cnt_next, w_cnt_sat;
    logic [32:0] w_cnt_plus;
    logic [31:0] r_m, r_k, r_c0;
    logic        r_error, w_error_next, w_latch;
    logic        r_lock_meta, r_lock_sync;
    logic [5:0]  w_addr;
    logic [31:0] w_data;

    // Synchroniser is held clear while the PLL is in reset so a stale lock cannot end WAITLOCK.
    always_ff @(posedge CLK_50M) begin
        if (RESET || r_state == StPllRst) begin
            r_lock_meta <= 1'b0;
            r_lock_sync <= 1'b0;
        end else begin
            r_lock_meta <= locked;
            r_lock_sync <= r_lock_meta;
        end
    end

    always_ff @(posedge CLK_50M) begin
        if (RESET) begin
            r_state <= StIdle;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_error <= 1'b0;
            r_m     <= '0;
            r_k     <= '0;
            r_c0    <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            r_cnt   <= w_cnt_next;
            r_error <= w_error_next;
            if (w_latch) begin
                r_m  <= m_val;
                r_k  <= k_val;
                r_c0 <= c0_val;
            end
        end
    end

    assign w_cnt_plus = {1'b0, r_cnt} + 33'd1;
    assign w_cnt_sat  = (r_cnt == '1) ? r_cnt : w_cnt_plus[31:0];

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_cnt_next   = w_cnt_sat;
        w_error_next = r_error;
        w_latch      = 1'b0;
        done         = 1'b0;
        case (r_state)
            StIdle: begin
                w_cnt_next = '0;
                if (start) begin
                    w_latch      = 1'b1;
                    w_error_next = 1'b0;
                    w_idx_next   = '0;
                    w_state_next = StWrite;
                end
            end
            StWrite: begin
                w_cnt_next = '0;
                if (!mgmt.mgmt_waitrequest) w_state_next = StGap;
            end
            StGap: begin
                if (w_cnt_plus >= 33'(GAP)) begin
                    w_cnt_next = '0;
                    if (r_idx == 3'd7) begin
                        w_state_next = StPllRst;
                    end else begin
                        w_idx_next   = r_idx + 3'd1;
                        w_state_next = StWrite;
                    end
                end
            end
            StPllRst: begin
                if (w_cnt_plus >= 33'(RST_CYCLES)) begin
                    w_cnt_next   = '0;
                    w_state_next = StWaitLock;
                end
            end
            StWaitLock: begin
                // Lock is checked first so it wins over a coincident timeout.
                if (r_lock_sync) begin
                    done         = 1'b1;
                    w_state_next = StIdle;
                end else if (w_cnt_plus >= 33'(LOCK_TIMEOUT)) begin
                    w_error_next = 1'b1;
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        w_addr = '0;
        w_data = '0;
        case (r_idx)
            3'd0: begin w_addr = 6'd0; w_data = 32'd0;       end
            3'd1: begin w_addr = 6'd4; w_data = r_m;         end
            3'd2: begin w_addr = 6'd7; w_data = r_k;         end
            3'd3: begin w_addr = 6'd3; w_data = 32'h0001_0000; end
            3'd4: begin w_addr = 6'd5; w_data = r_c0;        end
            3'd5: begin w_addr = 6'd9; w_data = 32'd1;       end
            3'd6: begin w_addr = 6'd8; w_data = 32'd7;       end
            3'd7: begin w_addr = 6'd2; w_data = 32'd0;       end
            default: begin w_addr = '0; w_data = '0; end
        endcase
    end

    assign mgmt.mgmt_write     = (r_state == StWrite);
    assign mgmt.mgmt_address   = (r_state == StWrite) ? w_addr : '0;
    assign mgmt.mgmt_writedata = (r_state == StWrite) ? w_data : '0;
    assign pll_reset           = (r_state == StPllRst);
    assign busy                = (r_state != StIdle);
    assign error               = r_error;
endmodule

// File: doc/pll_reconfig_seq.md
PLL_RECONFIG_SEQ -- requirements
Module: pll_reconfig_seq

Interface
REQ-001 SHALL have parameter GAP, default 8: idle cycles after each accepted write before the next write.
REQ-002 SHALL have parameter RST_CYCLES, default 8: pll_reset pulse width in cycles.
REQ-003 SHALL have parameter LOCK_TIMEOUT, default 50000000: maximum cycles to wait for lock after reset release.
REQ-004 SHALL have port CLK_50M  in  1  system and mgmt clock.
REQ-005 SHALL have port RESET  in  1  synchronous, active-high reset.
REQ-006 SHALL have port start  in  1  single-cycle request to begin reconfiguration.
REQ-007 SHALL have port m_val  in  32  M counter word, sampled on accepted start.
REQ-008 SHALL have port k_val  in  32  fractional K word, sampled on accepted start.
REQ-009 SHALL have port c0_val  in  32  C0 counter word, sampled on accepted start.
REQ-010 SHALL have port locked  in  1  PLL lock (asynchronous).
REQ-011 SHALL have port mgmt_waitrequest  in  1  reconfig-controller stall.
REQ-012 SHALL have port mgmt_write  out  1  write strobe.
REQ-013 SHALL have port mgmt_address  out  6  register address.
REQ-014 SHALL have port mgmt_writedata  out  32  register data.
REQ-015 SHALL have port pll_reset  out  1  PLL reset.
REQ-016 SHALL have port busy  out  1  high from accepted start until done or error.
REQ-017 SHALL have port done  out  1  one-cycle pulse on successful lock.
REQ-018 SHALL have port error  out  1  sticky lock-timeout flag, cleared by the next accepted start.

Function
REQ-019 SHALL synchronise locked through two flops; all lock decisions SHALL use the synchronised value.
REQ-020 SHALL accept start only in IDLE; start during any other state SHALL be ignored.
REQ-021 On an accepted start, SHALL latch m_val, k_val and c0_val, clear error, and set busy in the next cycle.
REQ-022 SHALL use states IDLE, WRITE, GAP, PLLRST, WAITLOCK.
REQ-023 SHALL issue exactly 8 writes in this order:
  - addr 0 data 0 (mode)
  - addr 4 data M
  - addr 7 data K
  - addr 3 data 0x10000 (N)
  - addr 5 data C0
  - addr 9 data 1 (charge pump)
  - addr 8 data 7 (bandwidth)
  - addr 2 data 0 (apply)
REQ-024 WRITE SHALL hold mgmt_write=1 and stable address/data until a cycle with mgmt_waitrequest=0; that cycle is the acceptance.
REQ-025 After acceptance, mgmt_write SHALL go 0 on the next cycle, and the block SHALL spend exactly GAP cycles in GAP before the next WRITE.
REQ-026 After the 8th GAP, SHALL enter PLLRST and hold pll_reset=1 for exactly RST_CYCLES cycles, then drive it 0.
REQ-027 WAITLOCK SHALL count cycles from reset release.
  - Synchronised locked=1 with count below LOCK_TIMEOUT: pulse done for 1 cycle, clear busy, go to IDLE.
  - Count reaching LOCK_TIMEOUT: set error, clear busy, go to IDLE; no done pulse.
REQ-028 If locked=1 and the timeout are reached in the same cycle, lock SHALL win (done, no error).
REQ-029 The lock timeout counter SHALL be 32 bits and SHALL saturate, never wrap.
REQ-030 mgmt_address and mgmt_writedata SHALL be 0 whenever mgmt_write=0.
REQ-031 done and start in the same cycle: start SHALL be ignored (state is not yet IDLE).

Reset
REQ-032 RESET=1 SHALL synchronously force:
  - state to IDLE
  - mgmt_write=0, mgmt_address=0, mgmt_writedata=0
  - pll_reset=0, busy=0, done=0, error=0
  - latched words and all counters to 0
REQ-033 RESET mid-operation, including during a stalled write or while pll_reset=1, SHALL abort immediately with no further writes; the next start after RESET falls SHALL run a full sequence.

Verification
REQ-034 start with M=0x00404, K=0xB33332DD, C0=0x20201, waitrequest=0, locked rises 100 cycles after reset release -> 8 writes in order (addr 0,4,7,3,5,9,8,2 with the REQ-023 data), each spaced 1+GAP cycles; pll_reset high exactly 8 cycles; done pulses once, 2-3 cycles after locked rises.
REQ-035 waitrequest held high 5 cycles on the K write -> mgmt_write stays 1 with addr 7, data 0xB33332DD for 6 cycles; the sequence otherwise matches REQ-034.
REQ-036 LOCK_TIMEOUT=1000, locked never rises -> error=1 and busy=0 exactly 1000 cycles after reset release; no done; the next start clears error.
REQ-037 second start pulse during GAP after the M write -> ignored; exactly 8 writes total; latched values unchanged even if m_val changes.
REQ-038 RESET asserted while pll_reset=1 -> next cycle pll_reset=0, busy=0, mgmt_write=0; no done; a start after reset runs a complete sequence.
REQ-039 locked already 1 throughout (lock not lost) -> done pulses 2 cycles after pll_reset falls; error remains 0.
